// File: rtl/stream_rr_arbiter_if.sv
// Bundles the N requester streams and the merged output stream of the
// round-robin arbiter. The arbiter uses the slave modport. The traffic
// source and sink side uses the master modport.
interface stream_rr_arbiter_if #(
   parameter int N  = 4,
   parameter int DW = 8
);
   localparam int IW = $clog2(N);

   logic [N-1:0]    valid_i;
   logic [N-1:0]    ready_o;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    last_i;
   logic            valid_o;
   logic            ready_i;
   logic [DW-1:0]   data_o;
   logic            last_o;
   logic [IW-1:0]   idx_o;

   modport slave (
      input  valid_i, data_i, last_i, ready_i,
      output ready_o, valid_o, data_o, last_o, idx_o
   );

   modport master (
      output valid_i, data_i, last_i, ready_i,
      input  ready_o, valid_o, data_o, last_o, idx_o
   );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-locked arbiter. It merges N valid/ready streams onto one
// output. Once a winner has presented a beat, the winner stays granted until
// its last beat is accepted. This keeps the output stable while stalled and
// never interleaves beats from different packets.
module stream_rr_arbiter #(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   stream_rr_arbiter_if.slave  bus
);
   localparam int IW = $clog2(N);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] lock_q, lock_d;

   logic [DW-1:0] data_arr [N];
   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] cand;
   logic [IW-1:0] sel_idx;
   logic          grant_en;
   logic          gate;
   logic          hs;

   // Returns (p + off) mod N. Both p and off are below N, so a single
   // subtraction is enough.
   function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= N) s = s - N;
      return IW'(s);
   endfunction

   // Returns (v + 1) mod N. This keeps ptr below N when N is not a power of two.
   function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
      if (v == IW'(N - 1)) return '0;
      return v + 1'b1;
   endfunction

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_unpack
         assign data_arr[gi] = bus.data_i[gi*DW +: DW];
      end
   endgenerate

   // Reset and clear both force the outputs to their idle values.
   assign gate = rst_i | clear_i;
   assign hs   = bus.valid_o & bus.ready_i;

   // Finds the first valid requester, starting the search at ptr and wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = rot_idx(ptr_q, i);
         if (!win_found && bus.valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Holds the state register: current state, priority pointer and locked requester.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
      end
   end

   // Computes the next state: lock onto a winner, advance ptr on a last beat,
   // and let clear_i take priority over any handshake.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      if (clear_i) begin
         state_d = IDLE;
         ptr_d   = '0;
         lock_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  if (hs && bus.last_i[win_idx]) begin
                     ptr_d = inc_mod(win_idx);
                  end else begin
                     state_d = LOCKED;
                     lock_d  = win_idx;
                  end
               end
            end
            LOCKED: begin
               if (hs && bus.last_i[lock_q]) begin
                  ptr_d   = inc_mod(lock_q);
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Drives the outputs: forward the selected requester, or all zeros when
   // nothing is granted.
   always_comb begin
      sel_idx     = (state_q == LOCKED) ? lock_q : win_idx;
      grant_en    = ~gate & ((state_q == LOCKED) | win_found);
      bus.valid_o = grant_en & bus.valid_i[sel_idx];
      bus.data_o  = grant_en ? data_arr[sel_idx] : '0;
      bus.last_o  = grant_en & bus.last_i[sel_idx];
      bus.idx_o   = grant_en ? sel_idx : '0;
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign bus.ready_o[gi] = grant_en & (sel_idx == IW'(gi)) & bus.ready_i;
      end
   endgenerate
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed test of stream_rr_arbiter. The stimulus pushes the beats it
// expects into a scoreboard. A monitor pops an entry at every output
// handshake and compares it.
module tb_stream_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic  clk   = 1'b0;
   logic  rst   = 1'b1;
   logic  clear = 1'b0;
   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t sb[$];

   stream_rr_arbiter_if #(.N(N), .DW(DW)) bus();

   stream_rr_arbiter #(.N(N), .DW(DW)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input int k, input logic [7:0] v);
      bus.data_i[k*DW +: DW] = v;
   endtask

   task automatic push(input int idx, input logic [7:0] d, input logic l);
      sb.push_back({2'(idx), d, l});
   endtask

   // The monitor checks each accepted output beat against the scoreboard.
   always @(negedge clk) begin : mon
      beat_t got;
      beat_t req;
      if (bus.valid_o && bus.ready_i) begin
         got = {bus.idx_o, bus.data_o, bus.last_o};
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL beat: unexpected idx=%0d data=0x%0h last=%0b, none required",
                     got.idx, got.data, got.last);
         end else begin
            req = sb.pop_front();
            if (got !== req) begin
               n_fail++;
               $display("FAIL beat: got idx=%0d data=0x%0h last=%0b, required idx=%0d data=0x%0h last=%0b",
                        got.idx, got.data, got.last, req.idx, req.data, req.last);
            end else begin
               $display("beat idx=%0d data=0x%0h last=%0b", got.idx, got.data, got.last);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.valid_i = '0;
      bus.last_i  = '0;
      bus.data_i  = '0;
      bus.ready_i = 1'b0;

      // Outputs must stay gated while reset is held, even with requests present.
      bus.valid_i = 4'b1111;
      bus.last_i  = 4'b1111;
      bus.ready_i = 1'b1;
      @(negedge clk);
      chk("rst valid_o", 32'(bus.valid_o), 32'd0);
      chk("rst ready_o", 32'(bus.ready_o), 32'd0);
      chk("rst data_o",  32'(bus.data_o),  32'd0);
      step();
      rst = 1'b0;
      bus.valid_i = 4'b0000;
      @(negedge clk);
      chk("idle valid_o", 32'(bus.valid_o), 32'd0);
      chk("idle ready_o", 32'(bus.ready_o), 32'd0);
      chk("idle idx_o",   32'(bus.idx_o),   32'd0);

      // All four requesters send single-beat packets, so the grant rotates 0,1,2,3,0,1,2,3.
      step();
      for (int k = 0; k < N; k++) set_d(k, 8'(8'h10 + k));
      bus.valid_i = 4'b1111;
      bus.last_i  = 4'b1111;
      for (int i = 0; i < 8; i++) push(i % N, 8'(8'h10 + (i % N)), 1'b1);
      repeat (8) step();
      bus.valid_i = 4'b0000;

      // Requester 1 sends a 3-beat packet while requester 2 waits. After it, ptr is 3.
      bus.valid_i = 4'b0110;
      bus.last_i  = 4'b0100;
      set_d(1, 8'h21);
      set_d(2, 8'h40);
      push(1, 8'h21, 1'b0);
      push(1, 8'h22, 1'b0);
      push(1, 8'h23, 1'b1);
      push(2, 8'h40, 1'b1);
      @(negedge clk);
      chk("pkt ready_o beat1", 32'(bus.ready_o), 32'b0010);
      step();
      set_d(1, 8'h22);
      @(negedge clk);
      chk("pkt ready_o beat2", 32'(bus.ready_o), 32'b0010);
      step();
      set_d(1, 8'h23);
      bus.last_i = 4'b0110;
      @(negedge clk);
      chk("pkt ready_o beat3", 32'(bus.ready_o), 32'b0010);
      step();
      bus.valid_i = 4'b0100;
      @(negedge clk);
      chk("pkt ready_o req2", 32'(bus.ready_o), 32'b0100);
      step();
      bus.valid_i = 4'b0000;

      // Wrap-around: with ptr=3, requester 3 beats requester 0. After this, ptr is 1.
      bus.valid_i = 4'b1001;
      bus.last_i  = 4'b1111;
      set_d(0, 8'h50);
      set_d(3, 8'h53);
      push(3, 8'h53, 1'b1);
      push(0, 8'h50, 1'b1);
      @(negedge clk);
      chk("wrap idx_o first", 32'(bus.idx_o), 32'd3);
      step();
      bus.valid_i = 4'b0001;
      @(negedge clk);
      chk("wrap idx_o second", 32'(bus.idx_o), 32'd0);
      step();
      bus.valid_i = 4'b0000;

      // Stall: requester 0 is held for 3 cycles, and requester 3 must not take the grant mid-stall.
      bus.ready_i = 1'b0;
      bus.valid_i = 4'b0001;
      set_d(0, 8'hA5);
      set_d(3, 8'h63);
      push(0, 8'hA5, 1'b1);
      push(3, 8'h63, 1'b1);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk($sformatf("stall%0d valid_o", s), 32'(bus.valid_o), 32'd1);
         chk($sformatf("stall%0d data_o", s),  32'(bus.data_o),  32'hA5);
         chk($sformatf("stall%0d idx_o", s),   32'(bus.idx_o),   32'd0);
         chk($sformatf("stall%0d ready_o", s), 32'(bus.ready_o), 32'd0);
         step();
         if (s == 0) bus.valid_i = 4'b1001;
      end
      bus.ready_i = 1'b1;
      @(negedge clk);
      chk("stall release ready_o", 32'(bus.ready_o), 32'b0001);
      step();
      bus.valid_i = 4'b1000;
      @(negedge clk);
      chk("after stall idx_o", 32'(bus.idx_o), 32'd3);
      step();
      bus.valid_i = 4'b0000;

      // Clear arrives during a LOCKED packet from requester 2. Afterwards ptr=0, so requester 1 wins.
      bus.valid_i = 4'b0100;
      bus.last_i  = 4'b0000;
      set_d(2, 8'h70);
      push(2, 8'h70, 1'b0);
      step();
      clear = 1'b1;
      bus.valid_i = 4'b0110;
      set_d(2, 8'h71);
      @(negedge clk);
      chk("clear ready_o", 32'(bus.ready_o), 32'd0);
      chk("clear valid_o", 32'(bus.valid_o), 32'd0);
      step();
      clear = 1'b0;
      set_d(1, 8'h31);
      set_d(2, 8'h72);
      bus.last_i = 4'b0110;
      push(1, 8'h31, 1'b1);
      push(2, 8'h72, 1'b1);
      @(negedge clk);
      chk("post-clear idx_o", 32'(bus.idx_o), 32'd1);
      step();
      bus.valid_i = 4'b0100;
      step();
      bus.valid_i = 4'b0000;

      // Reset arrives mid-packet (ptr was 3). After release, ptr=0, so requester 0 beats requester 3.
      bus.valid_i = 4'b0010;
      bus.last_i  = 4'b0000;
      set_d(1, 8'h81);
      push(1, 8'h81, 1'b0);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("mid-rst valid_o", 32'(bus.valid_o), 32'd0);
      chk("mid-rst ready_o", 32'(bus.ready_o), 32'd0);
      step();
      rst = 1'b0;
      bus.valid_i = 4'b1001;
      bus.last_i  = 4'b1111;
      set_d(0, 8'h90);
      set_d(3, 8'h93);
      push(0, 8'h90, 1'b1);
      push(3, 8'h93, 1'b1);
      @(negedge clk);
      chk("post-rst idx_o", 32'(bus.idx_o), 32'd0);
      step();
      bus.valid_i = 4'b1000;
      step();
      bus.valid_i = 4'b0000;
      step();
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
